axis_merge_rr: RTL and testbench

- N-to-1 AXI-Stream combiner; the return-direction counterpart of the 1-to-N stream replicator.
- Merges up to 4 independent AXIS sources into one master stream using beat-level round-robin arbitration.
- Tags each output beat with the index of its source port.
- A 2-entry output buffer registers the output side and sustains 1 beat/clk.

---
 rtl/axis_merge_pkg.sv | 41 ++++
 rtl/axis_skid_buf2.sv | 78 +++++++
 rtl/axis_merge_rr.sv | 107 ++++++++++
 tb/tb_axis_merge_rr.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_merge_pkg.sv
// Shared types and the round-robin scan used by the AXI-Stream merger.
package axis_merge_pkg;

  localparam int unsigned TID_W     = 2;
  localparam int unsigned MAX_PORTS = 4;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    BufEmpty = 2'd0,
    BufOne   = 2'd1,
    BufFull  = 2'd2
  } buf_cnt_e;

  // Result of one arbitration: which port wins, and whether any port won.
  typedef struct packed {
    logic             valid;
    logic [TID_W-1:0] idx;
  } rr_grant_t;

  // Scan ports last+1, last+2, ... (modulo n) and grant the first valid one.
  // last is always < n, so last + i stays below 2n and one subtraction wraps it.
  function automatic rr_grant_t rr_next(input logic [MAX_PORTS-1:0] valid_vec,
                                        input logic [TID_W-1:0]     last,
                                        input int unsigned          n);
    rr_grant_t   g;
    int unsigned cand;
    g = '0;
    for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
      cand = 32'(last) + i;
      if (cand >= n) begin
        cand = cand - n;
      end
      if ((i <= n) && !g.valid && valid_vec[cand[TID_W-1:0]]) begin
        g.valid = 1'b1;
        g.idx   = cand[TID_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry head/skid buffer that registers the merged output and keeps
// one beat per clock flowing while still honouring downstream backpressure.
module axis_skid_buf2
  import axis_merge_pkg::*;
#(
  parameter int unsigned DATA_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_push,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_pop,
  output logic              full
);

  buf_cnt_e          cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              pop;

  // A pop only counts when there is a beat to take.
  assign pop = out_pop && (cnt_q != BufEmpty);

  // Next-state for occupancy and the two storage entries.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case (cnt_q)
      BufEmpty: begin
        if (in_push) begin
          head_d = in_data;
          cnt_d  = BufOne;
        end
      end
      BufOne: begin
        if (in_push && !pop) begin
          skid_d = in_data;
          cnt_d  = BufFull;
        end else if (!in_push && pop) begin
          cnt_d = BufEmpty;
        end else if (in_push && pop) begin
          head_d = in_data;
        end
      end
      BufFull: begin
        // Upstream is stalled while full, so only a pop can happen here.
        if (pop) begin
          head_d = skid_q;
          cnt_d  = BufOne;
        end
      end
      default: begin
        cnt_d = BufEmpty;
      end
    endcase
  end

  // State registers; reset drops any buffered beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= BufEmpty;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = (cnt_q != BufEmpty);
  assign full      = (cnt_q == BufFull);

endmodule

// File: rtl/axis_merge_rr.sv
// N-to-1 AXI-Stream merger: beat-level round-robin over up to four sources,
// each output beat tagged with its source index in tid.
module axis_merge_rr
  import axis_merge_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned N_PORTS          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN1_tdata,
  input  logic                        S_AXIS_IN1_tvalid,
  output logic                        S_AXIS_IN1_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN2_tdata,
  input  logic                        S_AXIS_IN2_tvalid,
  output logic                        S_AXIS_IN2_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN3_tdata,
  input  logic                        S_AXIS_IN3_tvalid,
  output logic                        S_AXIS_IN3_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN4_tdata,
  input  logic                        S_AXIS_IN4_tvalid,
  output logic                        S_AXIS_IN4_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_DATA_tdata,
  output logic [TID_W-1:0]            M_AXIS_DATA_tid,
  output logic                        M_AXIS_DATA_tvalid,
  input  logic                        M_AXIS_DATA_tready
);

  localparam int unsigned ENTRY_W = AXIS_TDATA_WIDTH + TID_W;
  // Ports at or above N_PORTS are masked out so they can never win.
  localparam logic [MAX_PORTS-1:0] PORT_EN = MAX_PORTS'((32'd1 << N_PORTS) - 32'd1);

  logic [MAX_PORTS-1:0]        in_valid;
  logic [AXIS_TDATA_WIDTH-1:0] in_data [MAX_PORTS];
  logic [MAX_PORTS-1:0]        ready_vec;
  rr_grant_t                   gnt;
  logic [TID_W-1:0]            last_q, last_d;
  logic                        full;
  logic                        push;
  logic                        pop;
  logic [ENTRY_W-1:0]          push_entry;
  logic [ENTRY_W-1:0]          head_entry;

  assign in_valid = {S_AXIS_IN4_tvalid, S_AXIS_IN3_tvalid,
                     S_AXIS_IN2_tvalid, S_AXIS_IN1_tvalid} & PORT_EN;

  assign in_data[0] = S_AXIS_IN1_tdata;
  assign in_data[1] = S_AXIS_IN2_tdata;
  assign in_data[2] = S_AXIS_IN3_tdata;
  assign in_data[3] = S_AXIS_IN4_tdata;

  assign gnt = rr_next(in_valid, last_q, N_PORTS);

  // The granted port is always valid, so ready on it is the whole handshake.
  // Ready is held low while reset is asserted, independent of the clock.
  assign push = gnt.valid && !full && rst;

  // Only the granted port sees ready.
  always_comb begin
    ready_vec = '0;
    if (push) begin
      ready_vec[gnt.idx] = 1'b1;
    end
  end

  assign S_AXIS_IN1_tready = ready_vec[0];
  assign S_AXIS_IN2_tready = ready_vec[1];
  assign S_AXIS_IN3_tready = ready_vec[2];
  assign S_AXIS_IN4_tready = ready_vec[3];

  // Pointer moves to the last accepted port so the next scan starts after it.
  always_comb begin
    last_d = last_q;
    if (push) begin
      last_d = gnt.idx;
    end
  end

  // Pointer register; reset value gives port 0 first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= TID_W'(N_PORTS - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign push_entry = {gnt.idx, in_data[gnt.idx]};
  assign pop        = M_AXIS_DATA_tvalid && M_AXIS_DATA_tready;

  axis_skid_buf2 #(
    .DATA_W (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (push_entry),
    .in_push   (push),
    .out_data  (head_entry),
    .out_valid (M_AXIS_DATA_tvalid),
    .out_pop   (pop),
    .full      (full)
  );

  assign M_AXIS_DATA_tid   = head_entry[ENTRY_W-1 -: TID_W];
  assign M_AXIS_DATA_tdata = head_entry[AXIS_TDATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_merge_rr.sv
// Bench for axis_merge_rr: table of merge scenarios with a scoreboard of
// expected beats, plus hand-written backpressure and reset-while-full cases.
module tb_axis_merge_rr;

  typedef struct packed {
    logic [1:0]  tid;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [3:0]  vmask;
    int          n;
    logic [15:0] tids;   // beat i's source index in bits [2i+1:2i]
    int          stall;  // cycles with downstream ready low at the start
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data [4];
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [3:0]  s2_ready;
  logic [31:0] m_data, m2_data;
  logic [1:0]  m_tid, m2_tid;
  logic        m_valid, m2_valid;
  logic        m_ready;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    cnt [4];
  int    accepted, budget, cyc, first_in_cyc, last_out_cyc;
  logic [3:0] vmask_cur;
  bit    alt_en;
  logic  alt_tid;
  vec_t  vecs [7];

  always #5 clk = ~clk;

  axis_merge_rr #(.AXIS_TDATA_WIDTH(32), .N_PORTS(4)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_IN1_tdata(s_data[0]), .S_AXIS_IN1_tvalid(s_valid[0]), .S_AXIS_IN1_tready(s_ready[0]),
    .S_AXIS_IN2_tdata(s_data[1]), .S_AXIS_IN2_tvalid(s_valid[1]), .S_AXIS_IN2_tready(s_ready[1]),
    .S_AXIS_IN3_tdata(s_data[2]), .S_AXIS_IN3_tvalid(s_valid[2]), .S_AXIS_IN3_tready(s_ready[2]),
    .S_AXIS_IN4_tdata(s_data[3]), .S_AXIS_IN4_tvalid(s_valid[3]), .S_AXIS_IN4_tready(s_ready[3]),
    .M_AXIS_DATA_tdata(m_data), .M_AXIS_DATA_tid(m_tid),
    .M_AXIS_DATA_tvalid(m_valid), .M_AXIS_DATA_tready(m_ready)
  );

  // Two-port instance shares the inputs; its output is always drained.
  axis_merge_rr #(.AXIS_TDATA_WIDTH(32), .N_PORTS(2)) dut2 (
    .clk(clk), .rst(rst),
    .S_AXIS_IN1_tdata(s_data[0]), .S_AXIS_IN1_tvalid(s_valid[0]), .S_AXIS_IN1_tready(s2_ready[0]),
    .S_AXIS_IN2_tdata(s_data[1]), .S_AXIS_IN2_tvalid(s_valid[1]), .S_AXIS_IN2_tready(s2_ready[1]),
    .S_AXIS_IN3_tdata(s_data[2]), .S_AXIS_IN3_tvalid(s_valid[2]), .S_AXIS_IN3_tready(s2_ready[2]),
    .S_AXIS_IN4_tdata(s_data[3]), .S_AXIS_IN4_tvalid(s_valid[3]), .S_AXIS_IN4_tready(s2_ready[3]),
    .M_AXIS_DATA_tdata(m2_data), .M_AXIS_DATA_tid(m2_tid),
    .M_AXIS_DATA_tvalid(m2_valid), .M_AXIS_DATA_tready(1'b1)
  );

  function automatic logic [31:0] base(input int k);
    case (k)
      0:       return 32'h10;
      1:       return 32'h50;
      2:       return 32'hA0;
      default: return 32'hE0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_valid();
    for (int k = 0; k < 4; k++) begin
      s_valid[k] = vmask_cur[k] && (accepted < budget);
      s_data[k]  = base(k) + 32'(cnt[k]);
    end
  endtask

  // One clock: sample and check at the falling edge, update drivers after the rise.
  task automatic step();
    logic [3:0] hs;
    beat_t      e;
    @(negedge clk);
    check("ready_onehot", 64'($onehot0(s_ready)), 64'd1);
    check("ready_without_valid", 64'(s_ready & ~s_valid), 64'd0);
    check("n2_inert_ready", 64'(s2_ready[3:2]), 64'd0);
    hs = s_valid & s_ready;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_tid", 64'(m_tid), 64'(e.tid));
        check("out_data", 64'(m_data), 64'(e.data));
      end
      last_out_cyc = cyc;
    end
    if (alt_en && m2_valid) begin
      check("n2_tid_alternate", 64'(m2_tid), 64'(alt_tid));
      alt_tid = ~alt_tid;
    end
    if ((hs != 4'b0) && (first_in_cyc < 0)) first_in_cyc = cyc;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (hs[k]) cnt[k]++;
    end
    accepted += $countones(hs);
    drive_valid();
  endtask

  // Reset with inputs already valid: ready must still read low.
  task automatic do_reset(input logic [3:0] vmask);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) s_data[k] = 32'h0;
    s_valid = vmask;
    #2;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_tid", 64'(m_tid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    accepted     = 0;
    first_in_cyc = -1;
    last_out_cyc = -1;
    alt_tid      = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_record(input vec_t v);
    int    pc [4];
    int    t;
    logic  [1:0] tid;
    beat_t e;
    do_reset(v.vmask);
    budget    = v.n;
    vmask_cur = v.vmask;
    alt_en    = (v.vmask[1:0] == 2'b11);
    for (int k = 0; k < 4; k++) pc[k] = 0;
    for (int i = 0; i < v.n; i++) begin
      tid    = v.tids[2*i +: 2];
      e.tid  = tid;
      e.data = base(int'(tid)) + 32'(pc[tid]);
      exp_q.push_back(e);
      pc[tid]++;
    end
    m_ready = (v.stall == 0);
    drive_valid();
    for (int i = 0; i < v.stall; i++) begin
      if (m_valid && exp_q.size() > 0) begin
        check("stall_hold", 64'({m_tid, m_data}), 64'(exp_q[0]));
      end
      step();
    end
    if (v.stall > 0) begin
      check("stall_accepted", 64'(accepted), 64'd2);
      check("stall_ready_low", 64'(s_ready), 64'd0);
      check("stall_m_valid", 64'(m_valid), 64'd1);
    end
    m_ready = 1'b1;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      step();
      t++;
    end
    if (exp_q.size() != 0) check("timeout_beats_left", 64'(exp_q.size()), 64'd0);
    if (v.stall == 0) begin
      check("latency_throughput", 64'(last_out_cyc - first_in_cyc), 64'(v.n));
    end
    repeat (3) step();
    alt_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    m_ready   = 1'b0;
    s_valid   = 4'b0;
    vmask_cur = 4'b0;
    budget    = 0;
    cyc       = 0;
    alt_en    = 1'b0;
    for (int k = 0; k < 4; k++) s_data[k] = 32'h0;

    vecs[0] = '{vmask: 4'b0100, n: 4, tids: 16'h00AA, stall: 0};
    vecs[1] = '{vmask: 4'b1111, n: 8, tids: 16'hE4E4, stall: 0};
    vecs[2] = '{vmask: 4'b1010, n: 4, tids: 16'h00DD, stall: 0};
    vecs[3] = '{vmask: 4'b0011, n: 4, tids: 16'h0044, stall: 0};
    vecs[4] = '{vmask: 4'b1001, n: 4, tids: 16'h00CC, stall: 0};
    vecs[5] = '{vmask: 4'b0001, n: 3, tids: 16'h0000, stall: 0};
    vecs[6] = '{vmask: 4'b1111, n: 4, tids: 16'h00E4, stall: 6};

    for (int i = 0; i < 7; i++) run_record(vecs[i]);

    // Fill the buffer, then pulse reset mid-cycle: output clears at once.
    do_reset(4'b0000);
    budget    = 100;
    vmask_cur = 4'b1111;
    m_ready   = 1'b0;
    drive_valid();
    repeat (3) step();
    check("full_before_rst", 64'(m_valid), 64'd1);
    check("full_ready_low", 64'(s_ready), 64'd0);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_m_valid", 64'(m_valid), 64'd0);
    check("async_rst_m_data", 64'(m_data), 64'd0);
    check("async_rst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    m_ready = 1'b1;
    #1;
    check("post_rst_first_grant", 64'(s_ready), 64'd1);
    @(negedge clk);
    check("post_rst_first_grant_n2", 64'(s2_ready), 64'd1);
    vmask_cur = 4'b0000;
    drive_valid();
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
